// File: rtl/pe_mac_ctrl.sv
// PE MAC stage: streams one filter/IF window through a signed MAC and writes or accumulates
// the dot product into a PSUM entry. Define PE_MAC_SATURATE_EN for clamping arithmetic.
module pe_mac_ctrl #(
    parameter int unsigned IF_ADDR_LEN   = 4,
    parameter int unsigned FILT_ADDR_LEN = 4,
    parameter int unsigned PSUM_ADDR_LEN = 4,
    parameter int unsigned IF_WIDTH      = 8,
    parameter int unsigned FILT_WIDTH    = 8,
    parameter int unsigned PSUM_WIDTH    = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IF_ADDR_LEN-1:0]   if_base,
    input  logic [FILT_ADDR_LEN-1:0] filt_len,
    input  logic [PSUM_ADDR_LEN-1:0] psum_addr,
    input  logic                     psum_acc,
    output logic                     busy,
    output logic                     done,
    output logic [IF_ADDR_LEN-1:0]   if_raddr,
    input  logic [IF_WIDTH-1:0]      if_dout,
    output logic                     filt_ren,
    output logic [FILT_ADDR_LEN-1:0] filt_raddr,
    input  logic [FILT_WIDTH-1:0]    filt_dout,
    output logic [PSUM_ADDR_LEN-1:0] psum_raddr,
    input  logic [PSUM_WIDTH-1:0]    psum_dout,
    output logic                     psum_wen,
    output logic [PSUM_ADDR_LEN-1:0] psum_waddr,
    output logic [PSUM_WIDTH-1:0]    psum_din
);

    localparam int unsigned ProdW = IF_WIDTH + FILT_WIDTH;

    if (PSUM_WIDTH < ProdW) begin : g_width_check
        $error("PSUM_WIDTH must be at least IF_WIDTH + FILT_WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWrite,
        StDone
    } state_t;

    state_t                   state_q, state_d;
    logic [PSUM_WIDTH-1:0]    acc_q, acc_d;
    logic [FILT_ADDR_LEN-1:0] k_q, k_d;
    logic [FILT_ADDR_LEN-1:0] kd_q, kd_d;
    logic                     v_q, v_d;
    logic [IF_ADDR_LEN-1:0]   if_base_q, if_base_d;
    logic [FILT_ADDR_LEN-1:0] filt_len_q, filt_len_d;
    logic [PSUM_ADDR_LEN-1:0] psum_addr_q, psum_addr_d;
    logic                     psum_acc_q, psum_acc_d;

    logic signed [ProdW-1:0]      prod;
    logic signed [PSUM_WIDTH-1:0] prod_ext;
    logic [PSUM_WIDTH-1:0]        psum_base;

    // Two's-complement add, optionally clamped to the signed PSUM range.
    function automatic logic [PSUM_WIDTH-1:0] psum_add(input logic [PSUM_WIDTH-1:0] a,
                                                       input logic [PSUM_WIDTH-1:0] b);
`ifdef PE_MAC_SATURATE_EN
        logic [PSUM_WIDTH-1:0] sum;
        sum = a + b;
        if ((a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1]) && (sum[PSUM_WIDTH-1] != a[PSUM_WIDTH-1])) begin
            if (a[PSUM_WIDTH-1]) begin
                sum = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
            end else begin
                sum = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
            end
        end
        return sum;
`else
        return a + b;
`endif
    endfunction

    assign prod     = ProdW'($signed(if_dout)) * ProdW'($signed(filt_dout));
    assign prod_ext = PSUM_WIDTH'(prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            k_q         <= '0;
            kd_q        <= '0;
            v_q         <= 1'b0;
            if_base_q   <= '0;
            filt_len_q  <= '0;
            psum_addr_q <= '0;
            psum_acc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            kd_q        <= kd_d;
            v_q         <= v_d;
            if_base_q   <= if_base_d;
            filt_len_q  <= filt_len_d;
            psum_addr_q <= psum_addr_d;
            psum_acc_q  <= psum_acc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        k_d         = k_q;
        kd_d        = kd_q;
        v_d         = v_q;
        if_base_d   = if_base_q;
        filt_len_d  = filt_len_q;
        psum_addr_d = psum_addr_q;
        psum_acc_d  = psum_acc_q;
        filt_ren    = 1'b0;
        psum_wen    = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if_base_d   = if_base;
                    filt_len_d  = filt_len;
                    psum_addr_d = psum_addr;
                    psum_acc_d  = psum_acc;
                    acc_d       = '0;
                    k_d         = '0;
                    kd_d        = '0;
                    v_d         = 1'b0;
                    state_d     = (filt_len == '0) ? StWrite : StRun;
                end
            end
            StRun: begin
                // Issue tap k while the product of the previous tap is summed.
                if (k_q < filt_len_q) begin
                    filt_ren = 1'b1;
                    kd_d     = k_q;
                    v_d      = 1'b1;
                    k_d      = k_q + 1'b1;
                end else begin
                    v_d     = 1'b0;
                    state_d = StWrite;
                end
                if (v_q) begin
                    acc_d = psum_add(acc_q, prod_ext);
                end
            end
            StWrite: begin
                psum_wen = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign filt_raddr = filt_ren ? k_q : '0;
    assign if_raddr   = if_base_q + IF_ADDR_LEN'(kd_q);
    assign psum_raddr = psum_addr_q;
    assign psum_waddr = psum_addr_q;
    assign psum_base  = psum_acc_q ? psum_dout : '0;
    assign psum_din   = psum_wen ? psum_add(psum_base, acc_q) : '0;

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Directed bench for pe_mac_ctrl: scratchpad models around a default-width instance and a
// 16-bit PSUM instance used for the wrap/saturation case.
module tb_pe_mac_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] if_mem   [16];
    logic signed [7:0] filt_mem [16];
    logic [19:0]       psum_mem [16];
    logic [15:0]       psum16   [16];

    // Default-width instance
    logic        start = 1'b0;
    logic [3:0]  if_base = '0, filt_len = '0, psum_addr = '0;
    logic        psum_acc = 1'b0;
    logic        busy, done, filt_ren, psum_wen;
    logic [3:0]  if_raddr, filt_raddr, psum_raddr, psum_waddr;
    logic [7:0]  if_dout, filt_dout;
    logic [19:0] psum_dout, psum_din;

    assign if_dout   = if_mem[if_raddr];
    assign psum_dout = psum_mem[psum_raddr];
    always @(posedge clk) if (filt_ren) filt_dout <= filt_mem[filt_raddr];

    pe_mac_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .if_base(if_base), .filt_len(filt_len),
        .psum_addr(psum_addr), .psum_acc(psum_acc), .busy(busy), .done(done),
        .if_raddr(if_raddr), .if_dout(if_dout), .filt_ren(filt_ren), .filt_raddr(filt_raddr),
        .filt_dout(filt_dout), .psum_raddr(psum_raddr), .psum_dout(psum_dout),
        .psum_wen(psum_wen), .psum_waddr(psum_waddr), .psum_din(psum_din)
    );

    // 16-bit PSUM instance
    logic        s_start = 1'b0;
    logic [3:0]  s_if_base = '0, s_filt_len = '0, s_psum_addr = '0;
    logic        s_psum_acc = 1'b0;
    logic        s_busy, s_done, s_filt_ren, s_psum_wen;
    logic [3:0]  s_if_raddr, s_filt_raddr, s_psum_raddr, s_psum_waddr;
    logic [7:0]  s_if_dout, s_filt_dout;
    logic [15:0] s_psum_dout, s_psum_din;

    assign s_if_dout   = if_mem[s_if_raddr];
    assign s_psum_dout = psum16[s_psum_raddr];
    always @(posedge clk) if (s_filt_ren) s_filt_dout <= filt_mem[s_filt_raddr];

    pe_mac_ctrl #(.PSUM_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s_start), .if_base(s_if_base), .filt_len(s_filt_len),
        .psum_addr(s_psum_addr), .psum_acc(s_psum_acc), .busy(s_busy), .done(s_done),
        .if_raddr(s_if_raddr), .if_dout(s_if_dout), .filt_ren(s_filt_ren),
        .filt_raddr(s_filt_raddr), .filt_dout(s_filt_dout), .psum_raddr(s_psum_raddr),
        .psum_dout(s_psum_dout), .psum_wen(s_psum_wen), .psum_waddr(s_psum_waddr),
        .psum_din(s_psum_din)
    );

    // Event monitor, sampled at each rising edge
    int                 cyc = 0;
    int                 wr_cnt = 0, wr_edge = 0, done_cnt = 0, done_edge = 0;
    int                 busy_cnt = 0, ren_cnt = 0, ifr_n = 0;
    logic [3:0]         wr_addr = '0;
    logic signed [19:0] wr_data = '0;
    logic               ren_prev = 1'b0;
    logic [3:0]         ifr [64];
    int                 s_wr_cnt = 0, s_done_cnt = 0;
    logic signed [15:0] s_wr_data = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ren_prev <= filt_ren;
        if (psum_wen) begin
            wr_cnt  <= wr_cnt + 1;
            wr_edge <= cyc;
            wr_addr <= psum_waddr;
            wr_data <= psum_din;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= cyc;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (filt_ren) ren_cnt <= ren_cnt + 1;
        if (ren_prev && ifr_n < 64) begin
            ifr[ifr_n] <= if_raddr;
            ifr_n      <= ifr_n + 1;
        end
        if (s_psum_wen) begin
            s_wr_cnt  <= s_wr_cnt + 1;
            s_wr_data <= s_psum_din;
        end
        if (s_done) s_done_cnt <= s_done_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input int base, input int len, input int addr,
                          input bit acc, input bit poke, input int exp_data);
        int c0, wr0, dn0, bz0, rn0, n, lat;
        wr0 = wr_cnt; dn0 = done_cnt; bz0 = busy_cnt; rn0 = ren_cnt;
        @(negedge clk);
        if_base   = 4'(base);
        filt_len  = 4'(len);
        psum_addr = 4'(addr);
        psum_acc  = acc;
        start     = 1'b1;
        c0        = cyc;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done_cnt == dn0 && n < 60) begin
            start = poke && (n == 1);
            if (poke && n == 1) psum_addr = 4'(addr + 1);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        lat = (len == 0) ? 1 : len + 2;
        check_eq({tag, "_done_cnt"}, done_cnt - dn0, 1);
        check_eq({tag, "_wr_cnt"}, wr_cnt - wr0, 1);
        check_eq({tag, "_wr_edge"}, wr_edge - c0, lat);
        check_eq({tag, "_done_edge"}, done_edge - c0, lat + 1);
        check_eq({tag, "_wr_addr"}, int'(wr_addr), addr);
        check_eq({tag, "_wr_data"}, int'(wr_data), exp_data);
        check_eq({tag, "_busy_cycles"}, busy_cnt - bz0, lat + 1);
        check_eq({tag, "_ren_cycles"}, ren_cnt - rn0, len);
    endtask

    initial begin
        int f0, sdn0, n;
        for (int i = 0; i < 16; i++) begin
            if_mem[i] = '0; filt_mem[i] = '0; psum_mem[i] = '0; psum16[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_filt_ren", int'(filt_ren), 0);
        check_eq("rst_psum_wen", int'(psum_wen), 0);
        check_eq("rst_psum_din", int'(psum_din), 0);
        check_eq("rst_if_raddr", int'(if_raddr), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Overwrite: 1*5 + 2*6 + 3*7 + 4*8 = 70
        if_mem[2] = 1; if_mem[3] = 2; if_mem[4] = 3; if_mem[5] = 4;
        filt_mem[0] = 5; filt_mem[1] = 6; filt_mem[2] = 7; filt_mem[3] = 8;
        run_op("ovw", 2, 4, 3, 1'b0, 1'b0, 70);

        // Accumulate onto 100
        psum_mem[3] = 20'd100;
        run_op("acc", 2, 4, 3, 1'b1, 1'b0, 170);

        // Start while busy is ignored
        run_op("poke", 2, 4, 3, 1'b0, 1'b1, 70);

        // Address wrap and signed products: -6 - 4 + 16384
        if_mem[14] = -3; if_mem[15] = 4; if_mem[0] = -128;
        filt_mem[0] = 2; filt_mem[1] = -1; filt_mem[2] = -128;
        f0 = ifr_n;
        run_op("wrap", 14, 3, 1, 1'b0, 1'b0, 16374);
        check_eq("wrap_ifr_n", ifr_n - f0, 3);
        check_eq("wrap_ifr0", int'(ifr[f0]), 14);
        check_eq("wrap_ifr1", int'(ifr[f0+1]), 15);
        check_eq("wrap_ifr2", int'(ifr[f0+2]), 0);

        // Zero-length window
        psum_mem[5] = -20'sd9;
        run_op("zlen_acc", 0, 0, 5, 1'b1, 1'b0, -9);
        run_op("zlen_ovw", 0, 0, 5, 1'b0, 1'b0, 0);

        // Reset during the third RUN cycle
        if_mem[2] = 1; if_mem[3] = 2; if_mem[4] = 3; if_mem[5] = 4;
        filt_mem[0] = 5; filt_mem[1] = 6; filt_mem[2] = 7; filt_mem[3] = 8;
        f0 = wr_cnt; n = done_cnt;
        @(negedge clk);
        if_base = 4'd2; filt_len = 4'd4; psum_addr = 4'd3; psum_acc = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_filt_ren", int'(filt_ren), 0);
        check_eq("abort_filt_raddr", int'(filt_raddr), 0);
        check_eq("abort_if_raddr", int'(if_raddr), 0);
        check_eq("abort_psum_raddr", int'(psum_raddr), 0);
        check_eq("abort_psum_waddr", int'(psum_waddr), 0);
        check_eq("abort_psum_din", int'(psum_din), 0);
        repeat (8) @(negedge clk);
        check_eq("abort_no_write", wr_cnt - f0, 0);
        check_eq("abort_no_done", done_cnt - n, 0);
        rst = 1'b1;
        @(negedge clk);
        run_op("post_abort", 2, 4, 3, 1'b0, 1'b0, 70);

        // 16-bit PSUM: 4 * 127 * 127 = 64516 onto 32000
        for (int i = 0; i < 4; i++) begin
            if_mem[i] = 127; filt_mem[i] = 127;
        end
        psum16[2] = 16'd32000;
        sdn0 = s_done_cnt; f0 = s_wr_cnt;
        @(negedge clk);
        s_if_base = 4'd0; s_filt_len = 4'd4; s_psum_addr = 4'd2; s_psum_acc = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        n = 0;
        while (s_done_cnt == sdn0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("w16_done_cnt", s_done_cnt - sdn0, 1);
        check_eq("w16_wr_cnt", s_wr_cnt - f0, 1);
`ifdef PE_MAC_SATURATE_EN
        check_eq("w16_wr_data", int'(s_wr_data), 32767);
`else
        check_eq("w16_wr_data", int'(s_wr_data), 30980);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
